// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_pkg
//  Description : Shared constants for the branch resolve unit: PC width,
//                condition codes, FSM state encoding and target helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    localparam int c_pc_w = 16;

    // Branch condition codes
    localparam logic [2:0] c_cond_neq    = 3'b000;
    localparam logic [2:0] c_cond_eq     = 3'b001;
    localparam logic [2:0] c_cond_gt     = 3'b010;
    localparam logic [2:0] c_cond_lt     = 3'b011;
    localparam logic [2:0] c_cond_gte    = 3'b100;
    localparam logic [2:0] c_cond_lte    = 3'b101;
    localparam logic [2:0] c_cond_ovfl   = 3'b110;
    localparam logic [2:0] c_cond_uncond = 3'b111;

    // Resolve FSM state encoding
    localparam int              c_st_w     = 2;
    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_wait  = 2'd1;
    localparam logic [c_st_w-1:0] c_st_eval  = 2'd2;
    localparam logic [c_st_w-1:0] c_st_flush = 2'd3;

    // Branch target: modulo-2^16 add, carry out is dropped
    function automatic logic [c_pc_w-1:0] branch_target(
        input logic [c_pc_w-1:0] pc,
        input logic [c_pc_w-1:0] off_sext
    );
        return pc + off_sext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : ALU flag / branch request / redirect bundle between the
//                issue side (master) and the branch resolve unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int OFF_W = 9
) ();
    // ALU flag side
    logic                fs_issue;
    logic                alu_vld;
    logic                alu_ov;
    logic                alu_zr;
    logic                alu_ne;
    logic                flag_ov;
    logic                flag_zr;
    logic                flag_ne;
    logic                fs_full;
    // Branch request side
    logic                br_vld;
    logic                br_ready;
    logic [2:0]          br_cond;
    logic [c_pc_w-1:0]   br_pc;
    logic [OFF_W-1:0]    br_off;
    // Fetch redirect side
    logic                resolved;
    logic                redirect;
    logic [c_pc_w-1:0]   redirect_pc;
    logic                flush;

    modport master (
        output fs_issue, alu_vld, alu_ov, alu_zr, alu_ne,
        output br_vld, br_cond, br_pc, br_off,
        input  flag_ov, flag_zr, flag_ne, fs_full,
        input  br_ready, resolved, redirect, redirect_pc, flush
    );

    modport slave (
        input  fs_issue, alu_vld, alu_ov, alu_zr, alu_ne,
        input  br_vld, br_cond, br_pc, br_off,
        output flag_ov, flag_zr, flag_ne, fs_full,
        output br_ready, resolved, redirect, redirect_pc, flush
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : br_cond_eval
//  Description : Combinational branch condition evaluator,
//                (cond, Z, V, N) -> taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_cond_eval
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       taken
);
    // Decode condition code against the supplied flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            c_cond_neq:    taken = !z;
            c_cond_eq:     taken = z;
            c_cond_gt:     taken = !z && !n;
            c_cond_lt:     taken = n;
            c_cond_gte:    taken = z || !n;
            c_cond_lte:    taken = z || n;
            c_cond_ovfl:   taken = v;
            c_cond_uncond: taken = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Holds the architectural Z/V/N flags, counts in-flight
//                flag-setting ops and resolves conditional branches,
//                producing a one-cycle redirect and a multi-cycle flush.
//                Optional macro BRANCH_FWD_EN: resolve straight from the ALU
//                flags when the last outstanding op retires during WAIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int MAX_PEND  = 3,
    parameter int FLUSH_CYC = 2,
    parameter int OFF_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int                PEND_W       = $clog2(MAX_PEND + 1);
    localparam int                FCNT_W       = $clog2(FLUSH_CYC + 1);
    localparam logic [PEND_W-1:0] c_pend_max   = PEND_W'(MAX_PEND);
    localparam logic [FCNT_W-1:0] c_flush_init = FCNT_W'(FLUSH_CYC);

    logic [c_st_w-1:0] r_state, w_state_nxt;
    logic [PEND_W-1:0] r_pend;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_flag_ov, r_flag_zr, r_flag_ne;
    logic [2:0]        r_cond;
    logic [c_pc_w-1:0] r_pc;
    logic [OFF_W-1:0]  r_off;
    logic              r_resolved, r_redirect, r_flush;
    logic [c_pc_w-1:0] r_redirect_pc;
    logic              w_resolved_nxt, w_redirect_nxt, w_flush_nxt;
    logic [c_pc_w-1:0] w_redirect_pc_nxt;
    logic              w_accept, w_fwd, w_taken;
    logic              w_eval_z, w_eval_v, w_eval_n;
    logic [c_pc_w-1:0] w_off_sext;

    assign w_accept   = bus.br_vld && bus.br_ready;
    assign w_off_sext = c_pc_w'($signed(r_off));

`ifdef BRANCH_FWD_EN
    // Last outstanding op retiring with no new issue: its flags are final
    assign w_fwd    = (r_state == c_st_wait) && (r_pend == PEND_W'(1)) &&
                      bus.alu_vld && !bus.fs_issue;
    assign w_eval_z = w_fwd ? bus.alu_zr : r_flag_zr;
    assign w_eval_v = w_fwd ? bus.alu_ov : r_flag_ov;
    assign w_eval_n = w_fwd ? bus.alu_ne : r_flag_ne;
`else
    assign w_fwd    = 1'b0;
    assign w_eval_z = r_flag_zr;
    assign w_eval_v = r_flag_ov;
    assign w_eval_n = r_flag_ne;
`endif

    br_cond_eval u_cond_eval (
        .cond  (r_cond),
        .z     (w_eval_z),
        .v     (w_eval_v),
        .n     (w_eval_n),
        .taken (w_taken)
    );

    // Architectural flags: capture on ALU retire, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_ov <= 1'b0;
            r_flag_zr <= 1'b0;
            r_flag_ne <= 1'b0;
        end else if (bus.alu_vld) begin
            r_flag_ov <= bus.alu_ov;
            r_flag_zr <= bus.alu_zr;
            r_flag_ne <= bus.alu_ne;
        end
    end

    // In-flight counter: simultaneous issue/retire cancel, saturates both ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (bus.fs_issue && !bus.alu_vld && (r_pend != c_pend_max)) begin
            r_pend <= r_pend + 1'b1;
        end else if (bus.alu_vld && !bus.fs_issue && (r_pend != '0)) begin
            r_pend <= r_pend - 1'b1;
        end
    end

    // Latch the branch request on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond <= '0;
            r_pc   <= '0;
            r_off  <= '0;
        end else if (w_accept) begin
            r_cond <= bus.br_cond;
            r_pc   <= bus.br_pc;
            r_off  <= bus.br_off;
        end
    end

    // Flush length counter: load on FLUSH entry, count down while in FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if ((r_state != c_st_flush) && (w_state_nxt == c_st_flush)) begin
            r_fcnt <= c_flush_init;
        end else if (r_state == c_st_flush) begin
            r_fcnt <= r_fcnt - 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: branch waits until no flag-setting op is outstanding
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = ((r_pend == '0) && !bus.alu_vld) ? c_st_eval : c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_fwd) begin
                    w_state_nxt = w_taken ? c_st_flush : c_st_idle;
                end else if (r_pend == '0) begin
                    w_state_nxt = c_st_eval;
                end
            end
            c_st_eval:  w_state_nxt = w_taken ? c_st_flush : c_st_idle;
            c_st_flush: begin
                if (r_fcnt == FCNT_W'(1)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // FSM outputs: next values for the registered resolve/redirect/flush
    always_comb begin
        w_resolved_nxt    = 1'b0;
        w_redirect_nxt    = 1'b0;
        w_redirect_pc_nxt = r_redirect_pc;
        w_flush_nxt       = (r_state == c_st_flush);
        if ((r_state == c_st_eval) || w_fwd) begin
            w_resolved_nxt    = 1'b1;
            w_redirect_nxt    = w_taken;
            w_redirect_pc_nxt = branch_target(r_pc, w_off_sext);
        end
    end

    // Output registers; flush lags FLUSH state by one so it follows redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resolved    <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_resolved    <= w_resolved_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_flush       <= w_flush_nxt;
        end
    end

    assign bus.flag_ov     = r_flag_ov;
    assign bus.flag_zr     = r_flag_zr;
    assign bus.flag_ne     = r_flag_ne;
    assign bus.fs_full     = (r_pend == c_pend_max);
    assign bus.br_ready    = (r_state == c_st_idle);
    assign bus.resolved    = r_resolved;
    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.flush       = r_flush;

endmodule
`default_nettype wire
